// File: rtl/register_file_if.sv
// Register-file port bundle: write-back, decode read and issue signals, plus read data and stall.
// master = pipeline side driving requests, slave = register file.
interface register_file_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6
);
    logic              wb_regwr;
    logic [ADDR_W-1:0] wb_wrreg;
    logic [DATA_W-1:0] wb_write_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic              iss_valid;
    logic              iss_regwr;
    logic [ADDR_W-1:0] iss_wrreg;
    logic              stall;

    modport master (
        output wb_regwr, wb_wrreg, wb_write_data, rd_en, rs1_addr, rs2_addr,
        output iss_valid, iss_regwr, iss_wrreg,
        input  rs1_data, rs2_data, stall
    );

    modport slave (
        input  wb_regwr, wb_wrreg, wb_write_data, rd_en, rs1_addr, rs2_addr,
        input  iss_valid, iss_regwr, iss_wrreg,
        output rs1_data, rs2_data, stall
    );
endinterface

// File: rtl/register_file.sv
// Register file with busy scoreboard: 1-cycle registered reads, combinational stall (no other backpressure).
// Define REGFILE_BYPASS_EN to forward a same-cycle write-back to reads and to the stall check.
module register_file #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    register_file_if.slave  rf
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [NREG-1:0]   busy_view;
    logic [DATA_W-1:0] rs1_data_q;
    logic [DATA_W-1:0] rs1_data_d;
    logic [DATA_W-1:0] rs2_data_q;
    logic [DATA_W-1:0] rs2_data_d;
    logic [DATA_W-1:0] rs1_rd;
    logic [DATA_W-1:0] rs2_rd;
    logic              wb_wr_en;
    logic              stall;

    assign wb_wr_en = rf.wb_regwr && (rf.wb_wrreg != '0);

`ifdef REGFILE_BYPASS_EN
    // A register being written back this cycle is already resolved for the reader.
    always_comb begin
        busy_view = busy_q;
        if (wb_wr_en) busy_view[rf.wb_wrreg] = 1'b0;
    end
    assign rs1_rd = (wb_wr_en && rf.wb_wrreg == rf.rs1_addr) ? rf.wb_write_data : regs_q[rf.rs1_addr];
    assign rs2_rd = (wb_wr_en && rf.wb_wrreg == rf.rs2_addr) ? rf.wb_write_data : regs_q[rf.rs2_addr];
`else
    assign busy_view = busy_q;
    assign rs1_rd    = regs_q[rf.rs1_addr];
    assign rs2_rd    = regs_q[rf.rs2_addr];
`endif

    // busy_q is cleared during reset, so stall is inherently low then.
    assign stall = rf.rd_en && (busy_view[rf.rs1_addr] || busy_view[rf.rs2_addr]);

    always_comb begin
        busy_d = busy_q;
        if (rf.wb_regwr) busy_d[rf.wb_wrreg] = 1'b0;
        if (rf.iss_valid && rf.iss_regwr && !stall && rf.iss_wrreg != '0)
            busy_d[rf.iss_wrreg] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        if (rf.rd_en) begin
            rs1_data_d = rs1_rd;
            rs2_data_d = rs2_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            busy_q     <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            if (wb_wr_en) regs_q[rf.wb_wrreg] <= rf.wb_write_data;
            busy_q     <= busy_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
        end
    end

    assign rf.rs1_data = rs1_data_q;
    assign rf.rs2_data = rs2_data_q;
    assign rf.stall    = stall;
endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: directed scenarios plus random traffic against an array-based model.
// Expected read data is queued per cycle and popped by an independent monitor after each posedge.
module tb_register_file;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 6;
    localparam int NREG   = 1 << ADDR_W;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
    } exp_t;

    logic clk;
    logic rst_n;
    register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf();

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf)
    );

    exp_t              exp_q[$];
    logic [DATA_W-1:0] m_reg [NREG];
    bit                m_busy[NREG];
    logic [DATA_W-1:0] m_rs1;
    logic [DATA_W-1:0] m_rs2;
    int                n_checks = 0;
    int                n_pass   = 0;
    bit                mon_en   = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_rs1 = '0;
        m_rs2 = '0;
    endfunction

    task automatic set_idle();
        rf.wb_regwr = 1'b0; rf.wb_wrreg = '0; rf.wb_write_data = '0;
        rf.rd_en = 1'b0; rf.rs1_addr = '0; rf.rs2_addr = '0;
        rf.iss_valid = 1'b0; rf.iss_regwr = 1'b0; rf.iss_wrreg = '0;
    endtask

    // One clock cycle of stimulus; the model describes what the next posedge must produce.
    task automatic drive(input bit wr, input int wa, input logic [DATA_W-1:0] wd,
                         input bit rd, input int a1, input int a2,
                         input bit iv, input bit ir, input int ia);
        bit wr_hit;
        bit b1;
        bit b2;
        bit exp_stall;
        @(negedge clk);
        rf.wb_regwr = wr; rf.wb_wrreg = ADDR_W'(wa); rf.wb_write_data = wd;
        rf.rd_en = rd; rf.rs1_addr = ADDR_W'(a1); rf.rs2_addr = ADDR_W'(a2);
        rf.iss_valid = iv; rf.iss_regwr = ir; rf.iss_wrreg = ADDR_W'(ia);
        #1;
        wr_hit    = wr && (wa != 0);
        b1        = m_busy[a1] && !(BYP && wr_hit && wa == a1);
        b2        = m_busy[a2] && !(BYP && wr_hit && wa == a2);
        exp_stall = rd && (b1 || b2);
        chk("stall", {63'd0, rf.stall}, {63'd0, exp_stall});
        if (rd) begin
            m_rs1 = (a1 == 0) ? '0 : (BYP && wr_hit && wa == a1) ? wd : m_reg[a1];
            m_rs2 = (a2 == 0) ? '0 : (BYP && wr_hit && wa == a2) ? wd : m_reg[a2];
        end
        exp_q.push_back('{m_rs1, m_rs2});
        if (wr_hit) m_reg[wa] = wd;
        if (wr) m_busy[wa] = 1'b0;
        if (iv && ir && !exp_stall && ia != 0) m_busy[ia] = 1'b1;
    endtask

    task automatic idle();
        drive(0, 0, '0, 0, 0, 0, 0, 0, 0);
    endtask

    // Release reset on a negedge and resume scoreboard checking once the monitor is past its slot.
    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        set_idle();
        model_reset();
        exp_q.delete();
        @(posedge clk);
        #2;
        mon_en = 1'b1;
    endtask

    task automatic mid_cycle_reset();
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        #2;
        rf.rd_en = 1'b1; rf.rs1_addr = 6'd5; rf.rs2_addr = 6'd6;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rs1", rf.rs1_data, '0);
        chk("async_rst_rs2", rf.rs2_data, '0);
        chk("async_rst_stall", {63'd0, rf.stall}, '0);
        rf.wb_regwr = 1'b1; rf.wb_wrreg = 6'd5; rf.wb_write_data = 64'hAA;
        rf.iss_valid = 1'b1; rf.iss_regwr = 1'b1; rf.iss_wrreg = 6'd6;
        @(posedge clk);
        #1;
        chk("rst_hold_rs1", rf.rs1_data, '0);
        chk("rst_hold_stall", {63'd0, rf.stall}, '0);
        release_reset();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL read_queue: output cycle with no expected entry");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rs1_data", rf.rs1_data, e.d1);
                    chk("rs2_data", rf.rs2_data, e.d2);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();
        #3;
        rf.rd_en = 1'b1;
        #1;
        chk("reset_rs1", rf.rs1_data, '0);
        chk("reset_rs2", rf.rs2_data, '0);
        chk("reset_stall", {63'd0, rf.stall}, '0);
        @(posedge clk);
        @(posedge clk);
        release_reset();

        // Write reg5 then busy reg6, confirm, then reset mid-cycle; nothing must survive.
        drive(1, 5, 64'hA5, 0, 0, 0, 1, 1, 6);
        drive(0, 0, '0, 1, 5, 5, 0, 0, 0);
        mid_cycle_reset();
        drive(0, 0, '0, 1, 5, 6, 0, 0, 0);
        idle();

        // Basic write then read.
        drive(1, 3, 64'h1234, 0, 0, 0, 0, 0, 0);
        drive(0, 0, '0, 1, 3, 0, 0, 0, 0);
        idle();

        // Register zero ignores writes and never becomes busy.
        drive(1, 0, 64'hFFFF, 0, 0, 0, 0, 0, 0);
        drive(0, 0, '0, 1, 0, 0, 1, 1, 0);
        drive(0, 0, '0, 1, 0, 0, 0, 0, 0);

        // RAW hazard on reg7 resolved by write-back.
        drive(0, 0, '0, 0, 0, 0, 1, 1, 7);
        drive(0, 0, '0, 1, 0, 7, 0, 0, 0);
        drive(1, 7, 64'h99, 1, 0, 7, 0, 0, 0);
        drive(0, 0, '0, 1, 0, 7, 0, 0, 0);

        // Set wins over clear on reg9.
        drive(0, 0, '0, 0, 0, 0, 1, 1, 9);
        drive(1, 9, 64'h5, 0, 0, 0, 1, 1, 9);
        drive(0, 0, '0, 1, 9, 0, 0, 0, 0);

        // Same-cycle write and read of reg4.
        drive(1, 4, 64'h11, 0, 0, 0, 0, 0, 0);
        drive(1, 4, 64'h77, 1, 4, 4, 0, 0, 0);
        idle();
        drive(0, 0, '0, 1, 4, 9, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            int wa;
            int a1;
            int a2;
            int ia;
            wa = $urandom_range(0, 15);
            a1 = ($urandom_range(0, 7) == 0) ? $urandom_range(0, NREG - 1) : $urandom_range(0, 15);
            a2 = $urandom_range(0, 15);
            ia = $urandom_range(0, 15);
            drive($urandom_range(0, 1), wa, {$urandom, $urandom},
                  $urandom_range(0, 3) != 0, a1, a2,
                  $urandom_range(0, 1), $urandom_range(0, 3) != 0, ia);
        end

        idle();
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        chk("queue_drained", 64'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the register and data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 6, giving the register index width; register count is 2**ADDR_W.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 wb_regwr  input  1  write-back write enable from the write-back stage.
REQ-006 wb_wrreg  input  ADDR_W  write-back destination index.
REQ-007 wb_write_data  input  DATA_W  write-back data.
REQ-008 rd_en  input  1  decode read request.
REQ-009 rs1_addr, rs2_addr  input  ADDR_W each  source register indices.
REQ-010 rs1_data, rs2_data  output  DATA_W each  registered read data.
REQ-011 iss_valid  input  1  decode issues an instruction this cycle.
REQ-012 iss_regwr  input  1  the issued instruction writes a register.
REQ-013 iss_wrreg  input  ADDR_W  destination of the issued instruction.
REQ-014 stall  output  1  combinational hazard stall to decode.

Function
REQ-015 Storage SHALL be 2**ADDR_W registers of DATA_W bits; register 0 SHALL always read zero and ignore writes.
REQ-016 On posedge with wb_regwr=1 and wb_wrreg!=0, reg[wb_wrreg] SHALL take wb_write_data.
REQ-017 Read latency SHALL be 1 cycle: on posedge with rd_en=1, rs1_data/rs2_data SHALL load reg[rs1_addr]/reg[rs2_addr]; with rd_en=0 they SHALL hold.
REQ-018 The busy vector SHALL have one bit per register; bit 0 SHALL be constant 0.
REQ-019 Busy set: on posedge with iss_valid=1, iss_regwr=1, stall=0, iss_wrreg!=0, busy[iss_wrreg] SHALL become 1.
REQ-020 Busy clear: on posedge with wb_regwr=1, busy[wb_wrreg] SHALL become 0.
REQ-021 Set and clear of the same index in one cycle: set SHALL win (busy stays 1).
REQ-022 iss_valid while stall=1 SHALL NOT modify busy.
REQ-023 stall SHALL equal rd_en AND (busy[rs1_addr] OR busy[rs2_addr]), subject to REQ-030.
REQ-024 When stall=1, the read of REQ-017 SHALL still occur; decode SHALL discard the data.
REQ-025 rs1_addr==rs2_addr SHALL return identical data on both ports.

Reset
REQ-026 While rst_n=0, all registers, the busy vector, rs1_data and rs2_data SHALL be 0, regardless of clk.
REQ-027 stall SHALL be 0 while rst_n=0.
REQ-028 Deassertion of rst_n SHALL take effect at the next posedge; no write or issue during reset SHALL be retained.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN SHALL select write-to-read bypass.
REQ-030 With REGFILE_BYPASS_EN defined: a read whose index matches a same-cycle write (wb_regwr=1, wb_wrreg!=0) SHALL return wb_write_data, and that index SHALL be treated as not busy for stall.
REQ-031 Without REGFILE_BYPASS_EN: a same-cycle read SHALL return the old value, and the stall term SHALL use the un-cleared busy bit.

Verification
REQ-032 Reset: rst_n=0 mid-cycle after writing reg[5]=0xA5 -> rs1_data=0 immediately; a subsequent read of reg[5] returns 0.
REQ-033 Write/read: write reg[3]=0x1234, next cycle rd_en with rs1_addr=3 -> rs1_data=0x1234 one cycle later.
REQ-034 Zero register: write reg[0]=0xFFFF, read rs1_addr=0, rs2_addr=0 -> both 0; issue to reg[0] -> stall never asserts.
REQ-035 Hazard: issue wrreg=7, then rd_en with rs2_addr=7 -> stall=1; wb_regwr to 7 with data 0x99 -> stall=0 (same cycle with bypass, next cycle without); read returns 0x99.
REQ-036 Simultaneous: busy[9]=1; same cycle wb_regwr to 9 and issue to 9 -> busy[9] remains 1; read of 9 stalls.
REQ-037 Bypass: same-cycle write reg[4]=0x77 (old 0x11) and read rs1_addr=4 -> rs1_data=0x77 with REGFILE_BYPASS_EN, 0x11 without.
